// File: rtl/dynamic_disp_top.sv
// Six-digit multiplexed seven-segment driver: ina/inb/inc shown as two-digit decimals (00-15), active-low.
// Latency: one digit advance every DIVCLK_CNTMAX+1 clocks; inputs appear at the digit's next refresh (<= one frame).
// Backpressure: none; free-running scan, outputs are registered. Option macro: LEADING_ZERO_BLANK_EN.
module dynamic_disp_top #(
    parameter int DIVCLK_CNTMAX = 49999   // must be >= 1
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic [3:0] ina,
    input  logic [3:0] inb,
    input  logic [3:0] inc,
    output logic [5:0] seg_sel,
    output logic [7:0] seg_led
);

    localparam int CNT_W = (DIVCLK_CNTMAX < 2) ? 1 : $clog2(DIVCLK_CNTMAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVCLK_CNTMAX);

    // Segment patterns, active-low, dp bit [7] held at 1 (off).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;

    // Per-input decimal split.
    logic             a_tens, b_tens, c_tens;
    logic [3:0]       a_ones, b_ones, c_ones;

    // Digit chosen for the upcoming index, plus a blank request.
    logic [3:0]       dig_val;
    logic             dig_is_tens;
    logic             dig_blank;
    logic [7:0]       led_nxt;
    logic [5:0]       sel_nxt;

    // Convert a 0..9 digit to its active-low segment pattern; anything else is dark.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Scan divider: wraps at CNT_MAX, the wrap cycle is the tick.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

    // Index that the next tick will select; reset value 5 makes the first tick land on digit 0.
    always_comb begin
        idx_nxt = idx + 3'd1;
        if (idx == 3'd5) begin
            idx_nxt = 3'd0;
        end
    end

    // Digit scan index.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            idx <= 3'd5;
        end else if (tick) begin
            idx <= idx_nxt;
        end
    end

    // Binary to two decimal digits; values never exceed 15 so tens is 0 or 1.
    always_comb begin
        a_tens = (ina >= 4'd10);
        b_tens = (inb >= 4'd10);
        c_tens = (inc >= 4'd10);
        a_ones = a_tens ? (ina - 4'd10) : ina;
        b_ones = b_tens ? (inb - 4'd10) : inb;
        c_ones = c_tens ? (inc - 4'd10) : inc;
    end

    // Pick the digit for the index about to be shown.
    always_comb begin
        dig_val     = 4'd0;
        dig_is_tens = 1'b0;
        case (idx_nxt)
            3'd0: dig_val = c_ones;
            3'd1: begin dig_val = {3'b000, c_tens}; dig_is_tens = 1'b1; end
            3'd2: dig_val = b_ones;
            3'd3: begin dig_val = {3'b000, b_tens}; dig_is_tens = 1'b1; end
            3'd4: dig_val = a_ones;
            3'd5: begin dig_val = {3'b000, a_tens}; dig_is_tens = 1'b1; end
            default: begin dig_val = 4'd0; dig_is_tens = 1'b0; end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A zero tens digit goes dark while its select line still fires, so the frame timing is unchanged.
    assign dig_blank = dig_is_tens && (dig_val == 4'd0);
`else
    // Tens digit always shown, so leading zeros are visible.
    logic unused_is_tens;
    assign unused_is_tens = dig_is_tens;
    assign dig_blank      = 1'b0;
`endif

    // Segment and select patterns for the upcoming index.
    always_comb begin
        led_nxt = dig_blank ? SEG_BLANK : seg_decode(dig_val);
        sel_nxt = ~(6'b000001 << idx_nxt);
    end

    // Select and segments registered on the same tick so they never disagree; reset is dark.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            seg_sel <= 6'b111111;
            seg_led <= SEG_BLANK;
        end else if (tick) begin
            seg_sel <= sel_nxt;
            seg_led <= led_nxt;
        end
    end

endmodule

// File: tb/tb_dynamic_disp_top.sv
module tb_dynamic_disp_top;

    logic       clk_50M = 1'b0;
    logic       rst     = 1'b1;
    logic [3:0] ina     = 4'd1;
    logic [3:0] inb     = 4'd2;
    logic [3:0] inc     = 4'd3;
    logic [5:0] seg_sel;
    logic [7:0] seg_led;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] e123 [6];
    logic [7:0] eaef [6];
    logic [7:0] e678 [6];
    logic [7:0] e000 [6];

    dynamic_disp_top #(.DIVCLK_CNTMAX(1)) dut (
        .clk_50M (clk_50M),
        .rst     (rst),
        .ina     (ina),
        .inb     (inb),
        .inc     (inc),
        .seg_sel (seg_sel),
        .seg_led (seg_led)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    // Called just after the edge that selected digit n; checks it, checks it is held, then advances.
    task automatic scan_digit(input int n, input logic [7:0] exp_led, input string tag);
        logic [5:0] one;
        logic [5:0] exp_sel;
        one     = 6'b000001;
        exp_sel = ~(one << n);
        chk($sformatf("%s_sel%0d", tag, n), {26'd0, seg_sel}, {26'd0, exp_sel});
        chk($sformatf("%s_led%0d", tag, n), {24'd0, seg_led}, {24'd0, exp_led});
        step();
        chk($sformatf("%s_hold_sel%0d", tag, n), {26'd0, seg_sel}, {26'd0, exp_sel});
        chk($sformatf("%s_hold_led%0d", tag, n), {24'd0, seg_led}, {24'd0, exp_led});
        step();
    endtask

    initial begin
        eaef = '{8'h92, 8'hF9, 8'h99, 8'hF9, 8'hC0, 8'hF9};
`ifdef LEADING_ZERO_BLANK_EN
        e123 = '{8'hB0, 8'hFF, 8'hA4, 8'hFF, 8'hF9, 8'hFF};
        e678 = '{8'h80, 8'hFF, 8'hF8, 8'hFF, 8'h82, 8'hFF};
        e000 = '{8'hC0, 8'hFF, 8'hC0, 8'hFF, 8'hC0, 8'hFF};
`else
        e123 = '{8'hB0, 8'hC0, 8'hA4, 8'hC0, 8'hF9, 8'hC0};
        e678 = '{8'h80, 8'hC0, 8'hF8, 8'hC0, 8'h82, 8'hC0};
        e000 = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif

        // Reset state held over several edges.
        step();
        step();
        chk("rst_sel", {26'd0, seg_sel}, {26'd0, 6'b111111});
        chk("rst_led", {24'd0, seg_led}, {24'd0, 8'hFF});
        @(negedge clk_50M);
        rst = 1'b0;

        // First edge after release: still dark; second edge: digit 0.
        step();
        chk("first_edge_sel", {26'd0, seg_sel}, {26'd0, 6'b111111});
        chk("first_edge_led", {24'd0, seg_led}, {24'd0, 8'hFF});
        step();

        // Full frame 1,2,3 then wrap back to digit 0.
        for (int n = 0; n < 6; n++) scan_digit(n, e123[n], "f123");

        // Change inputs mid-hold of digit 0: it keeps its old value, later digits pick up the new one.
        ina = 4'hA; inb = 4'hE; inc = 4'hF;
        scan_digit(0, e123[0], "mid_aef");
        for (int n = 1; n < 6; n++) scan_digit(n, eaef[n], "mid_aef");
        for (int n = 0; n < 6; n++) scan_digit(n, eaef[n], "faef");

        ina = 4'd6; inb = 4'd7; inc = 4'd8;
        scan_digit(0, eaef[0], "mid_678");
        for (int n = 1; n < 6; n++) scan_digit(n, e678[n], "mid_678");
        for (int n = 0; n < 6; n++) scan_digit(n, e678[n], "f678");

        ina = 4'd0; inb = 4'd0; inc = 4'd0;
        scan_digit(0, e678[0], "mid_000");
        for (int n = 1; n < 6; n++) scan_digit(n, e000[n], "mid_000");
        scan_digit(0, e000[0], "f000");
        scan_digit(1, e000[1], "f000");

        // Asynchronous reset mid-hold of digit 2: dark before any further clock edge.
        rst = 1'b1;
        #1;
        chk("async_rst_sel", {26'd0, seg_sel}, {26'd0, 6'b111111});
        chk("async_rst_led", {24'd0, seg_led}, {24'd0, 8'hFF});
        step();
        chk("rst_hold_sel", {26'd0, seg_sel}, {26'd0, 6'b111111});
        @(negedge clk_50M);
        rst = 1'b0;
        step();
        chk("rerst_edge1_sel", {26'd0, seg_sel}, {26'd0, 6'b111111});
        step();
        for (int n = 0; n < 6; n++) scan_digit(n, e000[n], "post_rst");
        scan_digit(0, e000[0], "post_rst_wrap");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
